// File: rtl/ctmm_excl_snoop_bcast.sv
// Round-robin collector of namespace-entry access events feeding a FIFO that broadcasts one
// address per cycle to the exclusive monitors. Optional coalescing: `CTMM_SNOOP_COALESCE_EN.
module ctmm_excl_snoop_bcast #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic                          bcast_stall,
    output logic                          ext_addr_match,
    output logic [ADDR_W-1:0]             ext_access_addr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int RRW = $clog2(NUM_PORTS);

    logic [ADDR_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [RRW-1:0]    rr_ptr, gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_vld, coal_hit, accept, push, pop, empty, full;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = !empty && !bcast_stall;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        int             idx;
        logic [RRW-1:0] idx_c;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_c   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx_c = RRW'(idx);
            if (!gnt_vld && req_valid[idx_c]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_c;
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt_idx == RRW'(p)) gnt_addr = req_addr[p*ADDR_W +: ADDR_W];
        end
    end

`ifdef CTMM_SNOOP_COALESCE_EN
    // A pending broadcast of the same address already clears the monitors; the head entry
    // leaving this cycle no longer counts as pending.
    always_comb begin
        logic [PW-1:0] occ;
        logic [AW-1:0] slot;
        occ      = wr_ptr - rd_ptr;
        slot     = '0;
        coal_hit = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            slot = rd_ptr[AW-1:0] + AW'(k);
            if ((PW'(k) < occ) && !(k == 0 && pop) && (mem[slot] == gnt_addr))
                coal_hit = 1'b1;
        end
        coal_hit = coal_hit && gnt_vld;
    end
`else
    assign coal_hit = 1'b0;
`endif

    assign accept = gnt_vld && (!full || coal_hit);
    assign push   = accept && !coal_hit;
    assign wr_nxt = wr_ptr + PW'(push);
    assign rd_nxt = rd_ptr + PW'(pop);

    // Ready is held low while reset is asserted so no requester sees a spurious accept.
    always_comb begin
        req_ready = '0;
        if (accept && rst_n) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rr_ptr          <= '0;
            ext_addr_match  <= 1'b0;
            ext_access_addr <= '0;
            fifo_level      <= '0;
        end else begin
            wr_ptr         <= wr_nxt;
            rd_ptr         <= rd_nxt;
            fifo_level     <= wr_nxt - rd_nxt;
            ext_addr_match <= pop;
            if (pop) ext_access_addr <= mem[rd_ptr[AW-1:0]];
            if (accept) rr_ptr <= (gnt_idx == RRW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= gnt_addr;
    end
endmodule

// File: tb/tb_ctmm_excl_snoop_bcast.sv
// Scoreboard bench for ctmm_excl_snoop_bcast: accepted addresses are queued and checked
// against each broadcast pulse, plus grant, level and reset checks per scenario.
module tb_ctmm_excl_snoop_bcast;
    localparam int NP = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP*32-1:0] req_addr = '0;
    logic [NP-1:0]    req_ready;
    logic             bcast_stall = 1'b0;
    logic             ext_addr_match;
    logic [31:0]      ext_access_addr;
    logic [3:0]       fifo_level;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    always #5 clk = ~clk;

    ctmm_excl_snoop_bcast #(.NUM_PORTS(NP), .FIFO_DEPTH(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .bcast_stall(bcast_stall), .ext_addr_match(ext_addr_match),
        .ext_access_addr(ext_access_addr), .fifo_level(fifo_level)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        bcast_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // Queue every address the DUT is accepting this cycle.
    task automatic capture(output int n);
        n = 0;
        for (int p = 0; p < NP; p++) begin
            if (req_valid[p] && req_ready[p]) begin
                exp_q.push_back(req_addr[p*32 +: 32]);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        req_valid = '1;
        req_addr = {32'h4, 32'h3, 32'h2, 32'h1};
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL reset_ready: got %b, expected 0000", req_ready); end
        vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL reset_match: got %b, expected 0", ext_addr_match); end
        vectors++; if (ext_access_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h, expected 0", ext_access_addr); end
        vectors++; if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d, expected 0", fifo_level); end
        req_valid = '0;
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_single();
        int n;
        req_valid = 4'b0010;
        req_addr[63:32] = 32'h0000_0400;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL single_ready: got %b, expected 0010", req_ready); end
        capture(n);
        @(posedge clk); #1;
        req_valid = '0;
        vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL single_early: got %b, expected 0", ext_addr_match); end
        @(posedge clk); #1;
        vectors++; if (ext_addr_match !== 1'b1) begin miscompares++; $display("FAIL single_pulse: got %b, expected 1", ext_addr_match); end
        if (ext_addr_match) begin
            vectors++;
            if (exp_q.size() == 0) begin miscompares++; $display("FAIL single_bcast: got %h, expected none", ext_access_addr); end
            else begin e = exp_q.pop_front(); if (ext_access_addr !== e) begin miscompares++; $display("FAIL single_bcast: got %h, expected %h", ext_access_addr, e); end end
        end
        @(posedge clk); #1;
        vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL single_width: got %b, expected 0", ext_addr_match); end
    endtask

    task automatic test_round_robin();
        int n;
        apply_reset();
        for (int i = 0; i < NP; i++) req_addr[i*32 +: 32] = 32'h20 * (i + 1);
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            #1;
            vectors++; if (req_ready !== 4'(1 << (k % 4))) begin miscompares++; $display("FAIL rr_grant: cycle %0d got %b, expected %b", k, req_ready, 4'(1 << (k % 4))); end
            capture(n);
            @(posedge clk); #1;
            vectors++; if (ext_addr_match !== (k >= 1)) begin miscompares++; $display("FAIL rr_gap: cycle %0d got %b, expected %b", k, ext_addr_match, (k >= 1)); end
            vectors++; if (fifo_level !== 4'd1) begin miscompares++; $display("FAIL rr_level: cycle %0d got %0d, expected 1", k, fifo_level); end
            if (ext_addr_match) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL rr_bcast: got %h, expected none", ext_access_addr); end
                else begin e = exp_q.pop_front(); if (ext_access_addr !== e) begin miscompares++; $display("FAIL rr_bcast: got %h, expected %h", ext_access_addr, e); end end
            end
        end
        req_valid = '0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ext_addr_match) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL rr_bcast: got %h, expected none", ext_access_addr); end
                else begin e = exp_q.pop_front(); if (ext_access_addr !== e) begin miscompares++; $display("FAIL rr_bcast: got %h, expected %h", ext_access_addr, e); end end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr_drain: %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_full();
        int n;
        apply_reset();
        bcast_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b0001;
            req_addr[31:0] = 32'h100 + 32'h20 * i;
            #1;
            vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL full_fill_ready: entry %0d got %b, expected 0001", i, req_ready); end
            capture(n);
            @(posedge clk); #1;
        end
        vectors++; if (fifo_level !== 4'd8) begin miscompares++; $display("FAIL full_level: got %0d, expected 8", fifo_level); end
        req_valid = '1;
        #1;
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL full_backpressure: got %b, expected 0000", req_ready); end
        vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL full_stall_match: got %b, expected 0", ext_addr_match); end
        req_valid = '0;
        bcast_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            vectors++; if (ext_addr_match !== 1'b1) begin miscompares++; $display("FAIL full_drain_pulse: beat %0d got %b, expected 1", i, ext_addr_match); end
            if (ext_addr_match) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL full_bcast: got %h, expected none", ext_access_addr); end
                else begin e = exp_q.pop_front(); if (ext_access_addr !== e) begin miscompares++; $display("FAIL full_bcast: got %h, expected %h", ext_access_addr, e); end end
            end
        end
        vectors++; if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL full_empty_level: got %0d, expected 0", fifo_level); end
        @(posedge clk); #1;
        vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL full_extra_pulse: got %b, expected 0", ext_addr_match); end
    endtask

    task automatic test_wraparound();
        int n, sent, rcvd, cyc;
        apply_reset();
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 20 && cyc < 200) begin
            bcast_stall = ((cyc / 3) % 2) == 1;
            if (sent < 20) begin
                req_valid = 4'(1 << (sent % 4));
                req_addr[(sent % 4)*32 +: 32] = 32'hA000 + sent * 8;
            end else begin
                req_valid = '0;
            end
            #1;
            capture(n);
            sent += n;
            @(posedge clk); #1;
            if (ext_addr_match) begin
                rcvd++;
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL wrap_bcast: got %h, expected none", ext_access_addr); end
                else begin e = exp_q.pop_front(); if (ext_access_addr !== e) begin miscompares++; $display("FAIL wrap_bcast: got %h, expected %h", ext_access_addr, e); end end
            end
            cyc++;
        end
        req_valid = '0;
        bcast_stall = 1'b0;
        vectors++; if (rcvd != 20) begin miscompares++; $display("FAIL wrap_count: got %0d broadcasts, expected 20", rcvd); end
        @(posedge clk); #1;
        vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL wrap_duplicate: got %b, expected 0", ext_addr_match); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_loss: %0d left, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        req_valid = 4'b0100;
        req_addr[95:64] = 32'h4F0;
        #1; capture(n);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        vectors++; if (ext_addr_match !== 1'b1 || ext_access_addr !== 32'h4F0) begin miscompares++; $display("FAIL rmid_pre: got %b/%h, expected 1/000004f0", ext_addr_match, ext_access_addr); end
        void'(exp_q.pop_front());
        bcast_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 4'b0100;
            req_addr[95:64] = 32'h500 + 4 * i;
            #1; capture(n);
            @(posedge clk); #1;
        end
        vectors++; if (fifo_level !== 4'd5) begin miscompares++; $display("FAIL rmid_level5: got %0d, expected 5", fifo_level); end
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        vectors++; if (ext_access_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_addr: got %h, expected 0", ext_access_addr); end
        vectors++; if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL rmid_level: got %0d, expected 0", fifo_level); end
        vectors++; if (req_ready !== 4'b0) begin miscompares++; $display("FAIL rmid_ready: got %b, expected 0000", req_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '0;
        bcast_stall = 1'b0;
        exp_q.delete();
        repeat (4) begin
            @(posedge clk); #1;
            vectors++; if (ext_addr_match !== 1'b0) begin miscompares++; $display("FAIL rmid_stale: got %b/%h, expected 0", ext_addr_match, ext_access_addr); end
        end
        vectors++; if (fifo_level !== 4'd0) begin miscompares++; $display("FAIL rmid_post_level: got %0d, expected 0", fifo_level); end
    endtask

    task automatic test_coalesce();
        int n;
        logic [3:0] lvl_exp;
        apply_reset();
        bcast_stall = 1'b1;
        req_valid = 4'b0001;
        req_addr[31:0] = 32'h300;
        #1; capture(n);
        @(posedge clk); #1;
        vectors++; if (fifo_level !== 4'd1) begin miscompares++; $display("FAIL coal_first: got %0d, expected 1", fifo_level); end
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL coal_ready: got %b, expected 0001", req_ready); end
        capture(n);
`ifdef CTMM_SNOOP_COALESCE_EN
        if (n > 0) void'(exp_q.pop_back());
        lvl_exp = 4'd1;
`else
        lvl_exp = 4'd2;
`endif
        @(posedge clk); #1;
        req_valid = '0;
        vectors++; if (fifo_level !== lvl_exp) begin miscompares++; $display("FAIL coal_level: got %0d, expected %0d", fifo_level, lvl_exp); end
        bcast_stall = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ext_addr_match) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL coal_bcast: got %h, expected none", ext_access_addr); end
                else begin e = exp_q.pop_front(); if (ext_access_addr !== e) begin miscompares++; $display("FAIL coal_bcast: got %h, expected %h", ext_access_addr, e); end end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL coal_drain: %0d left, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full();
        test_wraparound();
        test_reset_mid();
        test_coalesce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
